// File: rtl/pc_gen_unit_pkg.sv
// Shared types and constants for the PC generation unit.
// Holds the FSM state encoding, the redirect-source encoding, the default
// boot/trap addresses, and a small alignment helper.
package pc_gen_unit_pkg;

    // Default addresses; the top module widens them to XLEN.
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

    // Control FSM: idle BOOT window after reset, then normal fetch.
    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    // Redirect source chosen by the arbiter, lowest to highest priority.
    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_JUMP   = 3'd2,
        RD_MRET   = 3'd3,
        RD_TRAP   = 3'd4
    } redirect_src_e;

    // A fetch target is word aligned when its two low bits are clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage : pc_gen_unit_pkg

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter for the PC generation unit.
// Picks the single highest-priority redirect (trap > mret > jump > branch)
// and its raw target; lower-priority requests in the same cycle are dropped.
module pc_redirect_arb
    import pc_gen_unit_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(DEFAULT_TRAP_VEC)
) (
    input  logic            branch_req,
    input  logic [XLEN-1:0] branch_tgt,
    input  logic            jump_req,
    input  logic [XLEN-1:0] jump_tgt,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic [XLEN-1:0] epc,
    output redirect_src_e   src,
    output logic [XLEN-1:0] tgt
);

    // Fixed-priority select of the winning redirect source and its target.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        src = RD_NONE;
        tgt = '0;
        if (trap_req) begin
            src = RD_TRAP;
            tgt = TRAP_VEC;
        end else if (mret_req) begin
            src = RD_MRET;
            tgt = epc;
        end else if (jump_req) begin
            src = RD_JUMP;
            tgt = jump_tgt;
        end else if (branch_req) begin
            src = RD_BRANCH;
            tgt = branch_tgt;
        end
    end

endmodule : pc_redirect_arb

// File: rtl/pc_gen_unit.sv
// PC generation unit: boot sequencing, fetch handshake and redirect handling.
// After reset the unit idles for BOOT_CYCLES clocks at BOOT_ADDR, then issues
// sequential fetch PCs, advancing only when the fetch stage accepts.
// Optional macro PC_MISALIGN_CHK_EN: misaligned mret/jump/branch targets are
// diverted to TRAP_VEC and reported on misalign_out/bad_addr_out; without it
// the low two target bits are simply cleared.
module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  BOOT_ADDR   = XLEN'(DEFAULT_BOOT_ADDR),
    parameter logic [XLEN-1:0]  TRAP_VEC    = XLEN'(DEFAULT_TRAP_VEC),
    parameter int               BOOT_CYCLES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            fetch_ready_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_tgt_in,
    input  logic            jump_in,
    input  logic [XLEN-1:0] jump_tgt_in,
    input  logic            trap_in,
    input  logic            mret_in,
    input  logic [XLEN-1:0] epc_in,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            misalign_out,
    output logic [XLEN-1:0] bad_addr_out
);

    // Boot counter sized to hold 0..BOOT_CYCLES-1 (at least one bit).
    localparam int              CNT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    pc_state_e        state;
    pc_state_e        state_next;
    logic [CNT_W-1:0] boot_cnt;
    logic [CNT_W-1:0] boot_cnt_next;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    redirect_src_e    rd_src;
    logic [XLEN-1:0]  rd_tgt;
    logic             run;

    pc_redirect_arb #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_arb (
        .branch_req (branch_taken_in),
        .branch_tgt (branch_tgt_in),
        .jump_req   (jump_in),
        .jump_tgt   (jump_tgt_in),
        .trap_req   (trap_in),
        .mret_req   (mret_in),
        .epc        (epc_in),
        .src        (rd_src),
        .tgt        (rd_tgt)
    );

    assign run = (state == ST_RUN);

    // FSM state and boot counter registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: state is reset here; non-blocking assignments keep all flops sampling pre-edge values.
        if (!rst_in) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
        end
    end

    // Next-state logic: count out the boot window, then stay in RUN.
    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        case (state)
            ST_BOOT: begin
                if (BOOT_CYCLES == 0 || boot_cnt == CNT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt + CNT_W'(1);
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

`ifdef PC_MISALIGN_CHK_EN
    logic            chk_hit;
    logic            misalign;
    logic [XLEN-1:0] bad_addr;

    // Checked redirects: only non-trap sources are subject to the alignment test.
    always_comb begin
        chk_hit = run && (rd_src != RD_NONE) && (rd_src != RD_TRAP)
                  && is_misaligned(rd_tgt[1:0]);
        pc_next = pc;
        if (run) begin
            if (chk_hit) begin
                pc_next = TRAP_VEC;
            end else if (rd_src != RD_NONE) begin
                pc_next = rd_tgt;
            end else if (fetch_ready_in) begin
                pc_next = pc + PC_STEP;
            end
        end
    end

    // One-cycle misalign pulse and sticky capture of the offending target.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            misalign <= 1'b0;
            bad_addr <= '0;
        end else begin
            misalign <= chk_hit;
            if (chk_hit) begin
                bad_addr <= rd_tgt;
            end
        end
    end

    assign misalign_out = misalign;
    assign bad_addr_out = bad_addr;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Unchecked redirects: the low two target bits are cleared.
    always_comb begin
        pc_next = pc;
        if (run) begin
            if (rd_src != RD_NONE) begin
                pc_next = rd_tgt & ALIGN_MASK;
            end else if (fetch_ready_in) begin
                pc_next = pc + PC_STEP;
            end
        end
    end

    assign misalign_out = 1'b0;
    assign bad_addr_out = '0;
`endif

    // Fetch PC register; held at BOOT_ADDR throughout BOOT.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc <= BOOT_ADDR;
        end else begin
            pc <= pc_next;
        end
    end

    assign pc_out        = pc;
    assign pc_valid_out  = run;
    assign pc_plus_4_out = pc + PC_STEP;

endmodule : pc_gen_unit

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit with default parameters (BOOT_CYCLES=2,
// BOOT_ADDR=0, TRAP_VEC=0x100). Expectations follow the PC_MISALIGN_CHK_EN
// setting used for the build.
module tb_pc_gen_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        fetch_ready_in;
    logic        branch_taken_in;
    logic [31:0] branch_tgt_in;
    logic        jump_in;
    logic [31:0] jump_tgt_in;
    logic        trap_in;
    logic        mret_in;
    logic [31:0] epc_in;
    logic [31:0] pc_out;
    logic        pc_valid_out;
    logic [31:0] pc_plus_4_out;
    logic        misalign_out;
    logic [31:0] bad_addr_out;

    int n_vec     = 0;
    int n_miscmp  = 0;

    pc_gen_unit dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .fetch_ready_in  (fetch_ready_in),
        .branch_taken_in (branch_taken_in),
        .branch_tgt_in   (branch_tgt_in),
        .jump_in         (jump_in),
        .jump_tgt_in     (jump_tgt_in),
        .trap_in         (trap_in),
        .mret_in         (mret_in),
        .epc_in          (epc_in),
        .pc_out          (pc_out),
        .pc_valid_out    (pc_valid_out),
        .pc_plus_4_out   (pc_plus_4_out),
        .misalign_out    (misalign_out),
        .bad_addr_out    (bad_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken_in = 1'b0;
        jump_in         = 1'b0;
        trap_in         = 1'b0;
        mret_in         = 1'b0;
    endtask

    initial begin
        rst_in         = 1'b0;
        fetch_ready_in = 1'b1;
        branch_tgt_in  = 32'h0;
        jump_tgt_in    = 32'h0;
        epc_in         = 32'h0;
        clear_redirects();

        // Reset state
        #12;
        check("rst_pc",       pc_out,        32'h0);
        check("rst_valid",    pc_valid_out,  32'h0);
        check("rst_plus4",    pc_plus_4_out, 32'h4);
        check("rst_misalign", misalign_out,  32'h0);
        check("rst_bad_addr", bad_addr_out,  32'h0);

        // Boot window: two invalid cycles, then 0x0, 0x4, 0x8
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("boot0_valid", pc_valid_out, 32'h0);
        tick();
        check("boot1_valid", pc_valid_out, 32'h0);
        check("boot1_pc",    pc_out,       32'h0);
        tick();
        check("run0_valid", pc_valid_out, 32'h1);
        check("run0_pc",    pc_out,       32'h0);
        tick();
        check("run1_pc", pc_out, 32'h4);
        tick();
        check("run2_pc", pc_out, 32'h8);
        check("run2_plus4", pc_plus_4_out, 32'hC);

        // Jump to 0x40, then stall for 3 cycles, then advance
        jump_in = 1'b1; jump_tgt_in = 32'h40;
        tick();
        check("jmp40_pc", pc_out, 32'h40);
        clear_redirects();
        fetch_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_pc", i), pc_out, 32'h40);
        end
        fetch_ready_in = 1'b1;
        tick();
        check("resume_pc",    pc_out,        32'h44);
        check("resume_plus4", pc_plus_4_out, 32'h48);

        // Priority: jump beats branch, trap beats both, mret beats jump
        branch_taken_in = 1'b1; branch_tgt_in = 32'h200;
        jump_in         = 1'b1; jump_tgt_in   = 32'h300;
        tick();
        check("jmp_over_br", pc_out, 32'h300);
        trap_in = 1'b1;
        tick();
        check("trap_over_all", pc_out, 32'h100);
        trap_in = 1'b0;
        mret_in = 1'b1; epc_in = 32'h500;
        tick();
        check("mret_over_jmp", pc_out, 32'h500);
        clear_redirects();

        // Branch alone, taken while fetch is stalled
        fetch_ready_in  = 1'b0;
        branch_taken_in = 1'b1; branch_tgt_in = 32'h208;
        tick();
        check("br_stalled", pc_out, 32'h208);
        clear_redirects();
        tick();
        check("br_hold", pc_out, 32'h208);
        fetch_ready_in = 1'b1;

        // Misaligned jump target
        jump_in = 1'b1; jump_tgt_in = 32'h202;
        tick();
        clear_redirects();
`ifdef PC_MISALIGN_CHK_EN
        check("mis_pc",   pc_out,       32'h100);
        check("mis_flag", misalign_out, 32'h1);
        check("mis_bad",  bad_addr_out, 32'h202);
        fetch_ready_in = 1'b0;
        tick();
        check("mis_pulse_end", misalign_out, 32'h0);
        check("mis_bad_held",  bad_addr_out, 32'h202);
        fetch_ready_in = 1'b1;
`else
        check("mis_pc",   pc_out,       32'h200);
        check("mis_flag", misalign_out, 32'h0);
        check("mis_bad",  bad_addr_out, 32'h0);
`endif

        // Wrap from 0xFFFF_FFFC to 0
        jump_in = 1'b1; jump_tgt_in = 32'hFFFF_FFFC;
        tick();
        clear_redirects();
        check("top_pc",    pc_out,        32'hFFFF_FFFC);
        check("top_plus4", pc_plus_4_out, 32'h0);
        tick();
        check("wrap_pc",    pc_out,        32'h0);
        check("wrap_plus4", pc_plus_4_out, 32'h4);
        tick();
        check("wrap_next", pc_out, 32'h4);

        // Reset during a pending jump: immediate return to boot state
        jump_in = 1'b1; jump_tgt_in = 32'h700;
        #1;
        rst_in = 1'b0;
        #1;
        check("mid_rst_pc",    pc_out,       32'h0);
        check("mid_rst_valid", pc_valid_out, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        check("reboot1_valid", pc_valid_out, 32'h0);
        check("reboot1_pc",    pc_out,       32'h0);
        tick();
        check("reboot2_valid", pc_valid_out, 32'h1);
        check("reboot2_pc",    pc_out,       32'h0);
        clear_redirects();
        tick();
        check("reboot3_pc", pc_out, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_pc_gen_unit
